// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP command decoder: opcodes, trigger
// sub-field encoding and the decoder state type.
package sump_pkg;

    // Short (single-byte) commands, bit 7 clear
    localparam logic [7:0] OP_RESET    = 8'h00;
    localparam logic [7:0] OP_ARM      = 8'h01;
    localparam logic [7:0] OP_ID       = 8'h02;
    localparam logic [7:0] OP_XON      = 8'h11;
    localparam logic [7:0] OP_XOFF     = 8'h13;

    // Long (opcode + 4 data bytes) commands, bit 7 set
    localparam logic [7:0] OP_DIV      = 8'h80;
    localparam logic [7:0] OP_CNT      = 8'h81;
    localparam logic [7:0] OP_FLGS     = 8'h82;
    localparam logic [7:0] OP_TRG_BASE = 8'hC0;

    // Low two bits of a trigger opcode select which stage register is loaded
    typedef enum logic [1:0] {
        TRG_MASK = 2'd0,
        TRG_VAL  = 2'd1,
        TRG_CFG  = 2'd2,
        TRG_NONE = 2'd3
    } trg_sub_t;

    typedef enum logic {
        IDLE = 1'b0,
        LONG = 1'b1
    } dec_state_t;

endpackage

// File: rtl/sump_cmd_dec.sv
// SUMP command decoder: turns received bytes into one-cycle control strobes
// and assembles the 32-bit payload of long commands onto cmd_o.
module sump_cmd_dec
    import sump_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk_i,
    input  logic                  rst_in,
    input  logic                  rx_stb_i,
    input  logic [7:0]            rx_data_i,
    output logic [31:0]           cmd_o,
    output logic [NUM_STAGES-1:0] set_mask_o,
    output logic [NUM_STAGES-1:0] set_val_o,
    output logic [NUM_STAGES-1:0] set_cfg_o,
    output logic                  set_div_o,
    output logic                  set_cnt_o,
    output logic                  set_flgs_o,
    output logic                  arm_o,
    output logic                  sreset_o,
    output logic                  id_o,
    output logic                  xon_o,
    output logic                  xoff_o
);

    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    // Decoder state and datapath
    dec_state_t      state_q, state_d;
    logic [7:0]      opc_q, opc_d;
    logic [1:0]      cnt_q, cnt_d;
    // Holds the first three data bytes; the fourth goes straight to cmd
    logic [23:0]     shift_q, shift_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [TW-1:0]   tmo_inc;

    // Registered strobes
    logic [NUM_STAGES-1:0] set_mask_q, set_mask_d;
    logic [NUM_STAGES-1:0] set_val_q, set_val_d;
    logic [NUM_STAGES-1:0] set_cfg_q, set_cfg_d;
    logic set_div_q, set_div_d;
    logic set_cnt_q, set_cnt_d;
    logic set_flgs_q, set_flgs_d;
    logic arm_q, arm_d;
    logic sreset_q, sreset_d;
    logic id_q, id_d;
    logic xon_q, xon_d;
    logic xoff_q, xoff_d;

    // Completion of the fourth data byte of a long command
    logic long_done;
    logic trg_hit;

    assign long_done = (state_q == LONG) && rx_stb_i && (cnt_q == 2'd3);
    assign trg_hit   = long_done && (opc_q[7:4] == OP_TRG_BASE[7:4]);

    // State register: all flops, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            opc_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            cmd_q      <= '0;
            tmo_q      <= '0;
            set_mask_q <= '0;
            set_val_q  <= '0;
            set_cfg_q  <= '0;
            set_div_q  <= 1'b0;
            set_cnt_q  <= 1'b0;
            set_flgs_q <= 1'b0;
            arm_q      <= 1'b0;
            sreset_q   <= 1'b0;
            id_q       <= 1'b0;
            xon_q      <= 1'b0;
            xoff_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            cmd_q      <= cmd_d;
            tmo_q      <= tmo_d;
            set_mask_q <= set_mask_d;
            set_val_q  <= set_val_d;
            set_cfg_q  <= set_cfg_d;
            set_div_q  <= set_div_d;
            set_cnt_q  <= set_cnt_d;
            set_flgs_q <= set_flgs_d;
            arm_q      <= arm_d;
            sreset_q   <= sreset_d;
            id_q       <= id_d;
            xon_q      <= xon_d;
            xoff_q     <= xoff_d;
        end
    end

    // Next state: byte assembly, payload capture and idle timeout
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        cmd_d   = cmd_q;
        tmo_d   = tmo_q;
        // Saturating increment so the counter never wraps
        tmo_inc = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TW'(1);
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_stb_i && rx_data_i[7]) begin
                    opc_d   = rx_data_i;
                    cnt_d   = '0;
                    state_d = LONG;
                end
            end
            LONG: begin
                if (rx_stb_i) begin
                    // A byte always beats a timeout firing in the same cycle
                    shift_d = {rx_data_i, shift_q[23:8]};
                    cnt_d   = cnt_q + 2'd1;
                    tmo_d   = '0;
                    if (cnt_q == 2'd3) begin
                        cmd_d   = {rx_data_i, shift_q};
                        state_d = IDLE;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: short opcodes in IDLE, long opcodes on completion
    always_comb begin
        set_mask_d = '0;
        set_val_d  = '0;
        set_cfg_d  = '0;
        set_div_d  = 1'b0;
        set_cnt_d  = 1'b0;
        set_flgs_d = 1'b0;
        arm_d      = 1'b0;
        sreset_d   = 1'b0;
        id_d       = 1'b0;
        xon_d      = 1'b0;
        xoff_d     = 1'b0;

        if ((state_q == IDLE) && rx_stb_i && !rx_data_i[7]) begin
            sreset_d = (rx_data_i == OP_RESET);
            arm_d    = (rx_data_i == OP_ARM);
            id_d     = (rx_data_i == OP_ID);
            xon_d    = (rx_data_i == OP_XON);
            xoff_d   = (rx_data_i == OP_XOFF);
        end

        if (long_done) begin
            set_div_d  = (opc_q == OP_DIV);
            set_cnt_d  = (opc_q == OP_CNT);
            set_flgs_d = (opc_q == OP_FLGS);
        end

        // Stages beyond NUM_STAGES simply match no bit
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (trg_hit && (opc_q[3:2] == 2'(i))) begin
                set_mask_d[i] = (trg_sub_t'(opc_q[1:0]) == TRG_MASK);
                set_val_d[i]  = (trg_sub_t'(opc_q[1:0]) == TRG_VAL);
                set_cfg_d[i]  = (trg_sub_t'(opc_q[1:0]) == TRG_CFG);
            end
        end
    end

    assign cmd_o      = cmd_q;
    assign set_mask_o = set_mask_q;
    assign set_val_o  = set_val_q;
    assign set_cfg_o  = set_cfg_q;
    assign set_div_o  = set_div_q;
    assign set_cnt_o  = set_cnt_q;
    assign set_flgs_o = set_flgs_q;
    assign arm_o      = arm_q;
    assign sreset_o   = sreset_q;
    assign id_o       = id_q;
    assign xon_o      = xon_q;
    assign xoff_o     = xoff_q;

endmodule
